dcache_controller: RTL
======================

// Module: dcache_controller
// PURPOSE
//  Sequencing FSM for the direct-mapped dcache datapath. Consumes hit/clean_miss/dirty_miss;
//  drives flush_mode, load_mode, the shared word counter, clear_selected_dirty_bit and
//  finish_new_line_install. Runs word-serial L2 writeback/refill over a valid/ready port
//  and signals request completion to the core.
// PARAMETERS
//  LINE_SIZE  32  bytes per cache line
//  XLEN       32  word width in bits; WORDS_PER_LINE = LINE_SIZE/(XLEN/8), CNT_W = $clog2(WORDS_PER_LINE)
// PORTS
//  clk                      in   1      rising-edge clock
//  reset                    in   1      synchronous, active-low reset
//  req_valid                in   1      core request pending; held until req_fulfilled
//  hit                      in   1      datapath: tag hit
//  clean_miss               in   1      datapath: miss, victim clean or invalid
//  dirty_miss               in   1      datapath: miss, victim dirty
//  req_fulfilled            out  1      1-cycle pulse: core request done (load data / store written)
//  flush_mode               out  1      datapath reads word[counter] for writeback
//  load_mode                out  1      datapath writes L2 word into word[counter]
//  counter                  out  CNT_W  word index for flush/load and l2_address low bits
//  clear_selected_dirty_bit out  1      1-cycle pulse after last writeback word
//  finish_new_line_install  out  1      1-cycle pulse: set valid and tag for req_set
//  l2_req_valid             out  1      L2 word transfer request
//  l2_req_write             out  1      1=write (writeback), 0=read (refill)
//  l2_req_ready             in   1      L2 accepts write / returns read data this cycle
// BEHAVIOUR
//  States: IDLE, WRITEBACK, WB_DONE, FILL, INSTALL. Reset (reset==0 at edge): state=IDLE,
//   counter=0, all outputs 0. Reset mid-transfer aborts immediately; no partial-line pulses.
//  IDLE: req_valid&hit -> req_fulfilled=1 same cycle (combinational), stay IDLE.
//   req_valid&clean_miss -> FILL; req_valid&dirty_miss -> WRITEBACK; counter:=0.
//   !req_valid -> no outputs asserted.
//  WRITEBACK: flush_mode=1, l2_req_valid=1, l2_req_write=1. Each cycle l2_req_ready=1:
//   counter++; on counter==WORDS_PER_LINE-1 & ready -> WB_DONE, counter wraps to 0.
//   ready low: hold counter and outputs (stall, no timeout).
//  WB_DONE: clear_selected_dirty_bit=1 for one cycle -> FILL.
//  FILL: load_mode=1, l2_req_valid=1, l2_req_write=0. Datapath write enable is the combination
//   load_mode & l2_req_ready. Each ready: counter++; last word & ready -> INSTALL, counter=0.
//  INSTALL: finish_new_line_install=1 one cycle -> IDLE. The next cycle re-compares and
//   completes as a hit (miss latency = 2 + WORDS_PER_LINE stall-free cycles for clean miss,
//   3 + 2*WORDS_PER_LINE for dirty miss).
//  req_valid dropping during a miss: line transaction still completes to IDLE; no req_fulfilled.
//  flush_mode and load_mode are never high together; l2_req_valid is only high in WRITEBACK/FILL.
//  hit together with a miss flag is illegal input (assert in simulation); hit takes priority.
// CONFIGURATION
//  DCACHE_CTRL_PERF_EN defined: adds outputs perf_hits, perf_clean_misses,
//   perf_dirty_misses (32 bits each, saturating). Each counts IDLE-state evaluations
//   with req_valid; the post-install re-hit is not counted. Cleared by reset.
//  Not defined: ports and counters absent; FSM behaviour identical.
// TESTING
//  1 reset low 2 cycles mid-FILL (counter=3) -> next cycle IDLE, counter=0, l2_req_valid=0.
//  2 req_valid=1, hit=1 in IDLE -> req_fulfilled=1 same cycle; no L2 traffic.
//  3 clean_miss, l2_req_ready always 1, WORDS_PER_LINE=8 -> 8 FILL cycles with counter 0..7,
//    install pulse, req_fulfilled 10 cycles after the miss.
//  4 dirty_miss -> 8 write beats (counter 0..7), clear_selected_dirty_bit pulse, 8 read beats,
//    install pulse; flush/load never overlap.
//  5 l2_req_ready toggling 1,0,0,1 in WRITEBACK -> counter advances only on ready cycles, outputs held.
//  6 req_valid dropped at FILL beat 2 -> fill completes, IDLE, req_fulfilled never pulses.
//  (PERF_EN) 3 hits, 1 clean, 1 dirty -> perf counters 3/1/1.

Source files
------------

// File: rtl/dcache_controller.sv
// Sequencing FSM for the direct-mapped dcache: hit completion, word-serial L2 writeback and refill.
// Optional performance counters are enabled with `define DCACHE_CTRL_PERF_EN.
module dcache_controller #(
  parameter  int unsigned LINE_SIZE      = 32,
  parameter  int unsigned XLEN           = 32,
  localparam int unsigned WORDS_PER_LINE = LINE_SIZE / (XLEN / 8),
  localparam int unsigned CNT_W          = $clog2(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             hit,
  input  logic             clean_miss,
  input  logic             dirty_miss,
  output logic             req_fulfilled,
  output logic             flush_mode,
  output logic             load_mode,
  output logic [CNT_W-1:0] counter,
  output logic             clear_selected_dirty_bit,
  output logic             finish_new_line_install,
  output logic             l2_req_valid,
  output logic             l2_req_write,
  input  logic             l2_req_ready
`ifdef DCACHE_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_hits,
  output logic [31:0]      perf_clean_misses,
  output logic [31:0]      perf_dirty_misses
`endif
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITEBACK,
    WB_DONE,
    FILL,
    INSTALL
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] counter_nxt;

  // State and word counter registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= state_nxt;
      counter <= counter_nxt;
    end
  end

  // Next-state, counter and mode decode
  always_comb begin
    state_nxt                = state;
    counter_nxt              = counter;
    req_fulfilled            = 1'b0;
    flush_mode               = 1'b0;
    load_mode                = 1'b0;
    clear_selected_dirty_bit = 1'b0;
    finish_new_line_install  = 1'b0;
    l2_req_valid             = 1'b0;
    l2_req_write             = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (hit) begin
            req_fulfilled = 1'b1;
          end else if (dirty_miss) begin
            state_nxt   = WRITEBACK;
            counter_nxt = '0;
          end else if (clean_miss) begin
            state_nxt   = FILL;
            counter_nxt = '0;
          end
        end
      end
      WRITEBACK: begin
        flush_mode   = 1'b1;
        l2_req_valid = 1'b1;
        l2_req_write = 1'b1;
        if (l2_req_ready) begin
          if (counter == LAST_WORD) begin
            state_nxt   = WB_DONE;
            counter_nxt = '0;
          end else begin
            counter_nxt = counter + CNT_W'(1);
          end
        end
      end
      WB_DONE: begin
        clear_selected_dirty_bit = 1'b1;
        state_nxt                = FILL;
      end
      FILL: begin
        load_mode    = 1'b1;
        l2_req_valid = 1'b1;
        if (l2_req_ready) begin
          if (counter == LAST_WORD) begin
            state_nxt   = INSTALL;
            counter_nxt = '0;
          end else begin
            counter_nxt = counter + CNT_W'(1);
          end
        end
      end
      INSTALL: begin
        finish_new_line_install = 1'b1;
        state_nxt               = IDLE;
      end
      default: begin
        state_nxt   = IDLE;
        counter_nxt = '0;
      end
    endcase
  end

  // Hit and miss flags are mutually exclusive when the FSM evaluates a request
  always_ff @(posedge clk) begin
    if (reset && state == IDLE && req_valid) begin
      assert (!(hit && (clean_miss || dirty_miss)))
        else $error("dcache_controller: hit asserted together with a miss flag");
    end
  end

`ifdef DCACHE_CTRL_PERF_EN
  // The cycle after INSTALL is the re-compare of the refilled line; it is not a new request
  logic post_install;

  always_ff @(posedge clk) begin
    if (!reset) begin
      post_install      <= 1'b0;
      perf_hits         <= '0;
      perf_clean_misses <= '0;
      perf_dirty_misses <= '0;
    end else begin
      post_install <= (state == INSTALL);
      if (state == IDLE && req_valid && !post_install) begin
        if (hit) begin
          if (perf_hits != '1) perf_hits <= perf_hits + 32'(1);
        end else if (dirty_miss) begin
          if (perf_dirty_misses != '1) perf_dirty_misses <= perf_dirty_misses + 32'(1);
        end else if (clean_miss) begin
          if (perf_clean_misses != '1) perf_clean_misses <= perf_clean_misses + 32'(1);
        end
      end
    end
  end
`endif

endmodule
